// File: rtl/demux_1_to_n_stream.sv
// demux_1_to_n_stream: registered 1-to-N valid/ready demux with addressed and round-robin scatter modes
module demux_1_to_n_stream #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 8,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   mode,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [SEL_W-1:0]       rr_ptr,
  output logic [7:0]             drop_cnt
);
  typedef logic [2**SEL_W-1:0] pad_t;
  logic [N_OUT-1:0] out_valid_q, out_valid_d;
  logic [N_OUT*WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d, t;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic in_range, accept, drop;
  pad_t free;
  assign t = mode ? rr_ptr_q : sel;
  assign in_range = 32'(t) < N_OUT;
  // a channel can take a beat in the same cycle its consumer drains it
  assign free = pad_t'(~out_valid_q | out_ready);
  assign in_ready = in_range ? free[t] : 1'b1;
  assign accept = in_valid && in_ready && in_range;
  assign drop = in_valid && !in_range;
  always_comb begin
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d = out_data_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (accept && t == SEL_W'(k)) begin
        out_valid_d[k] = 1'b1;
        out_data_d[k*WIDTH +: WIDTH] = in_data;
      end
    end
    rr_ptr_d = (accept && mode) ? ((32'(rr_ptr_q) == N_OUT-1) ? '0 : rr_ptr_q + 1'b1) : rr_ptr_q;
    drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= '0;
      out_data_q <= '0;
      rr_ptr_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      rr_ptr_q <= rr_ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign rr_ptr = rr_ptr_q;
  assign drop_cnt = drop_cnt_q;
endmodule

// File: doc/demux_1_to_n_stream.md
# demux_1_to_n_stream

Parametrised, registered 1-to-N demultiplexer with valid/ready handshaking, the clocked successor to the combinational 1-to-8 demux. Each input beat is steered to one of N_OUT output channels, either by an explicit select (addressed mode) or by an internal round-robin pointer (scatter mode), and held in a one-entry per-channel output register until the downstream consumer takes it. It sits between a single producer and N parallel consumers.

## Interface

- WIDTH, 8, data width in bits (>= 1)
- N_OUT, 8, number of output channels (2..16)
- SEL_W, $clog2(N_OUT), select/pointer width; derived, not overridden

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat present
- in_ready  output  1  input beat accepted this cycle when in_valid && in_ready
- in_data  input  WIDTH  input beat payload
- sel  input  SEL_W  target channel in addressed mode; ignored in scatter mode
- mode  input  1  0 = addressed, 1 = round-robin scatter
- out_valid  output  N_OUT  per-channel output register full
- out_ready  input  N_OUT  per-channel consumer ready
- out_data  output  N_OUT*WIDTH  channel k payload at bits [k*WIDTH +: WIDTH]
- rr_ptr  output  SEL_W  current round-robin target
- drop_cnt  output  8  count of beats dropped for out-of-range sel, saturating

## Operation

- Target channel t: mode=1 -> rr_ptr; mode=0 -> sel. mode and sel are sampled in the accepting cycle only.
- Per-channel register k is "free" when out_valid[k]=0, or when out_valid[k]=1 and out_ready[k]=1 in the same cycle (drain and refill allowed).
- in_ready = 1 if t is in range and register t is free; in_ready = 1 if mode=0 and sel >= N_OUT (drop path).
- Accept (in_valid && in_ready, t in range): out_data[t] <= in_data, out_valid[t] <= 1.
- Drop (mode=0, sel >= N_OUT, in_valid): beat consumed, no channel written, drop_cnt increments, saturating at 255. Out-of-range sel is possible only for non-power-of-2 N_OUT.
- Drain: out_valid[k] && out_ready[k] with no refill of k -> out_valid[k] <= 0. out_data[k] holds its last value.
- Channels are independent. Any number can drain in the same cycle as one accept.
- rr_ptr advances by 1 only on an accepted (non-dropped) beat in mode=1, wrapping N_OUT-1 -> 0. It holds otherwise, including while in mode=0, so a return to mode=1 resumes where it left off.
- While a stalled channel blocks round-robin (register full, no drain), in_ready=0. The pointer does not skip; strict order is preserved.
- Out-of-range rr_ptr cannot occur.

## Timing

- Reset (asynchronous assert, synchronous-to-clk deassert by the environment):
  - out_valid = 0, out_data = 0, rr_ptr = 0, drop_cnt = 0.
  - in_ready still follows its combinational rule: 1 when t is in range and free.
- Reset mid-operation: held beats are discarded; no output handshake completes in the reset cycle.
- Latency: beat accepted at edge n is visible on out_valid[t]/out_data[t] after edge n, i.e. in cycle n+1.
- Throughput:
  - One beat per cycle into any channel whose consumer holds out_ready=1.
  - Back-to-back beats to the same channel with out_ready=1 sustain full rate.
  - Without a drain, a channel takes one beat, then blocks.
- in_ready is combinational from in-range decode, out_valid[t] and out_ready[t]. There is no path from in_valid to in_ready.
- out_valid and out_data are registered outputs. Once out_valid[k]=1, out_data[k] is stable until that channel handshakes.

## Test plan

- Reset and addressed fill:
  - Stimulus: assert rst mid-stream with out_valid=8'h05; release; N_OUT=8, mode=0, out_ready=0.
  - Send in_data=8'hA0+k with sel=k for k=0..7.
  - Response: all outputs zero immediately on rst. One cycle after each accept, out_valid bit k sets. Final out_valid=8'hFF, out_data[k]=8'hA0+k.
- Backpressure on a full channel:
  - Stimulus: with channel 3 full and out_ready[3]=0, present sel=3, in_data=8'h55.
  - Response: in_ready=0 and out_data[3] unchanged. Raise out_ready[3] -> in_ready=1 that cycle, and out_data[3]=8'h55 next cycle with out_valid[3]=1.
- Round-robin scatter:
  - Stimulus: mode=1, all out_ready=1, 10 consecutive beats 8'h10..8'h19.
  - Response: channels 0..7 then 0,1 receive them in order. rr_ptr sequence is 0..7,0,1 then 2. in_ready stays 1 throughout.
- Round-robin stall:
  - Stimulus: mode=1, rr_ptr=2, channel 2 full, out_ready[2]=0.
  - Response: in_ready=0 and rr_ptr stays 2 for 5 cycles.
  - Switch to mode=0 and send sel=4, 8'h77: accepted, rr_ptr still 2.
- Out-of-range drop (N_OUT=5):
  - Stimulus: mode=0, 300 beats with sel=6.
  - Response: in_ready=1 every cycle, out_valid stays 0, drop_cnt saturates at 255.
- Simultaneous drain and refill:
  - Stimulus: channel 1 full with 8'h11, out_ready[1]=1, same-cycle beat sel=1, 8'h22.
  - Response: accepted. Next cycle out_valid[1]=1, out_data[1]=8'h22, with no bubble.
